// File: rtl/sseg_mux_decoder_if.sv
// Multiplexed 7-segment link plus the decoded frame it produces.
// The master drives segment/anode lines; the slave (decoder) returns the recovered frame.
interface sseg_mux_decoder_if;
  logic [7:0]  sseg;
  logic [3:0]  an;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  bad_glyph;
  logic        frame_valid;
  logic        anode_err;
  logic        stale;

  modport master (
    output sseg, an,
    input  digits, dp, blank, bad_glyph, frame_valid, anode_err, stale
  );

  modport slave (
    input  sseg, an,
    output digits, dp, blank, bad_glyph, frame_valid, anode_err, stale
  );
endinterface

// File: rtl/sseg_mux_decoder.sv
// Recovers the four hex digits, dp and blank state from a time-multiplexed 7-segment bus
// and publishes them as one coherent frame once every anode has been captured.
module sseg_mux_decoder #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic              clk,
  input logic              reset,
  sseg_mux_decoder_if.slave bus
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StWait, StSettle, StHold} state_e;

  logic [7:0]     sseg_meta, sseg_sync;
  logic [3:0]     an_meta, an_sync;
  state_e         state_q;
  logic [3:0]     an_lat;
  logic [7:0]     sseg_lat;
  logic [CntW-1:0] cnt;
  logic [3:0]     seen;
  logic [15:0]    sh_nib;
  logic [3:0]     sh_dp, sh_blank, sh_bad;
  logic [15:0]    digits_q;
  logic [3:0]     dp_q, blank_q, bad_q;
  logic           fv_q, aerr_q;
  logic [ToW-1:0] tcnt;

  logic           an_one, an_multi, same, capture, publish;
  logic [1:0]     cap_idx;
  logic [5:0]     dec;

  // Returns {bad, blank, nibble}; nibble is 0 for blank and bad patterns.
  function automatic logic [5:0] decode_glyph(input logic [6:0] seg);
    logic [5:0] r;
    r = 6'b10_0000;
    case (seg)
      7'b0000001: r = {2'b00, 4'h0};
      7'b1001111: r = {2'b00, 4'h1};
      7'b0010010: r = {2'b00, 4'h2};
      7'b0000110: r = {2'b00, 4'h3};
      7'b1001100: r = {2'b00, 4'h4};
      7'b0100100: r = {2'b00, 4'h5};
      7'b0100000: r = {2'b00, 4'h6};
      7'b0001111: r = {2'b00, 4'h7};
      7'b0000000: r = {2'b00, 4'h8};
      7'b0000100: r = {2'b00, 4'h9};
      7'b0001000: r = {2'b00, 4'hA};
      7'b1100000: r = {2'b00, 4'hB};
      7'b0110001: r = {2'b00, 4'hC};
      7'b1000010: r = {2'b00, 4'hD};
      7'b0110000: r = {2'b00, 4'hE};
      7'b0111000: r = {2'b00, 4'hF};
      7'b1111111: r = 6'b01_0000;
      default:    r = 6'b10_0000;
    endcase
    return r;
  endfunction

  // Lines idle high, so the synchronizers reset to the inactive level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sseg_meta <= 8'hFF;
      sseg_sync <= 8'hFF;
      an_meta   <= 4'hF;
      an_sync   <= 4'hF;
    end else begin
      sseg_meta <= bus.sseg;
      sseg_sync <= sseg_meta;
      an_meta   <= bus.an;
      an_sync   <= an_meta;
    end
  end

  always_comb begin
    an_one   = ($countones(~an_sync) == 1);
    an_multi = ($countones(~an_sync) > 1);
    same     = (an_sync == an_lat) && (sseg_sync == sseg_lat);
    capture  = (state_q == StSettle) && same && (cnt == CntW'(SETTLE_CYCLES - 1));
    publish  = (seen == 4'hF);
    dec      = decode_glyph(sseg_lat[6:0]);
    cap_idx  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!an_lat[i]) cap_idx = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StWait;
      an_lat   <= 4'hF;
      sseg_lat <= 8'hFF;
      cnt      <= '0;
      seen     <= 4'h0;
      sh_nib   <= 16'h0;
      sh_dp    <= 4'h0;
      sh_blank <= 4'h0;
      sh_bad   <= 4'h0;
      digits_q <= 16'h0;
      dp_q     <= 4'h0;
      blank_q  <= 4'h0;
      bad_q    <= 4'h0;
      fv_q     <= 1'b0;
      aerr_q   <= 1'b0;
      tcnt     <= '0;
    end else begin
      fv_q <= 1'b0;
      if (an_multi) aerr_q <= 1'b1;

      unique case (state_q)
        StWait: begin
          if (an_one) begin
            an_lat   <= an_sync;
            sseg_lat <= sseg_sync;
            cnt      <= '0;
            state_q  <= StSettle;
          end
        end
        StSettle: begin
          if (!same) begin
            an_lat   <= an_sync;
            sseg_lat <= sseg_sync;
            cnt      <= '0;
            state_q  <= an_one ? StSettle : StWait;
          end else if (capture) begin
            state_q <= StHold;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        StHold: begin
          // Segment changes on the held anode are ignored until the anode moves.
          if (an_sync != an_lat) begin
            if (an_one) begin
              an_lat   <= an_sync;
              sseg_lat <= sseg_sync;
              cnt      <= '0;
              state_q  <= StSettle;
            end else begin
              state_q <= StWait;
            end
          end
        end
        default: state_q <= StWait;
      endcase

      if (capture) begin
        sh_nib[{cap_idx, 2'b00} +: 4] <= dec[3:0];
        sh_dp[cap_idx]    <= ~sseg_lat[7];
        sh_blank[cap_idx] <= dec[4];
        sh_bad[cap_idx]   <= dec[5];
      end

      if (publish) begin
        digits_q <= sh_nib;
        dp_q     <= sh_dp;
        blank_q  <= sh_blank;
        bad_q    <= sh_bad;
        fv_q     <= 1'b1;
        seen     <= capture ? (4'b0001 << cap_idx) : 4'h0;
      end else if (capture) begin
        seen[cap_idx] <= 1'b1;
      end

      if (capture) begin
        tcnt <= '0;
      end else if (tcnt != ToW'(TIMEOUT_CYCLES)) begin
        tcnt <= tcnt + ToW'(1);
      end
    end
  end

  assign bus.digits      = digits_q;
  assign bus.dp          = dp_q;
  assign bus.blank       = blank_q;
  assign bus.bad_glyph   = bad_q;
  assign bus.frame_valid = fv_q;
  assign bus.anode_err   = aerr_q;
  assign bus.stale       = (tcnt == ToW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_sseg_mux_decoder.sv
// Scoreboard bench: a glyph-table model predicts each frame, a monitor checks every frame_valid.
module tb_sseg_mux_decoder;

  localparam int Settle   = 4;
  localparam int Timeout  = 100;
  localparam int MinDwell = 2 + Settle + 1;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  bad;
  } frame_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   fv_count = 0;
  int   fv_cyc = 0;
  int   drv_cyc = 0;

  frame_t     exp_q[$];
  frame_t     m_shadow;
  logic [3:0] m_seen;

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  sseg_mux_decoder_if bus ();

  sseg_mux_decoder #(
    .SETTLE_CYCLES (Settle),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hex_pat(input int v, input bit dp_on);
    logic [6:0] g;
    g = glyph[v];
    return {~dp_on, g};
  endfunction

  // Model of one captured digit: look the pattern up in the glyph table.
  task automatic model_capture(input int idx, input logic [7:0] pat);
    logic [3:0] nib;
    bit         bl, bd, found;
    nib = 4'h0; bl = 0; bd = 0; found = 0;
    if (pat[6:0] == 7'h7F) begin
      bl = 1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (glyph[i] == pat[6:0]) begin
          nib = 4'(i);
          found = 1;
        end
      end
      if (!found) bd = 1;
    end
    m_shadow.digits[idx*4 +: 4] = nib;
    m_shadow.dp[idx]    = ~pat[7];
    m_shadow.blank[idx] = bl;
    m_shadow.bad[idx]   = bd;
    m_seen[idx] = 1'b1;
    if (m_seen == 4'hF) begin
      exp_q.push_back(m_shadow);
      m_seen = 4'h0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic show(input int idx, input logic [7:0] pat, input int dwell, input int gap);
    step();
    bus.an   = ~(4'b0001 << idx);
    bus.sseg = pat;
    drv_cyc  = cyc;
    if (dwell >= MinDwell) model_capture(idx, pat);
    repeat (dwell - 1) step();
    if (gap > 0) begin
      step();
      bus.an   = 4'hF;
      bus.sseg = 8'hFF;
      repeat (gap - 1) step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_digits"}, {16'h0, bus.digits}, 32'h0);
    chk({tag, "_flags"}, {20'h0, bus.dp, bus.blank, bus.bad_glyph}, 32'h0);
    chk({tag, "_fv"}, {31'h0, bus.frame_valid}, 32'h0);
    chk({tag, "_anode_err"}, {31'h0, bus.anode_err}, 32'h0);
    chk({tag, "_stale"}, {31'h0, bus.stale}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (reset && bus.frame_valid) begin
      fv_count++;
      fv_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame_unexpected: got digits=%h with no frame expected", bus.digits);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        chk("frame", {4'h0, bus.digits, bus.dp, bus.blank, bus.bad_glyph}, {4'h0, e});
      end
    end
  end

  initial begin
    int n, g, f, t, prev, idx, r, dwell, gap;
    logic [7:0] pat;
    m_shadow = '0;
    m_seen   = 4'h0;
    bus.an   = 4'hF;
    bus.sseg = 8'hFF;
    reset    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    step();
    reset = 1'b1;

    // 3,2,1 with digit 3 blank
    n = fv_count;
    show(0, hex_pat(3, 0), 10, 1);
    show(1, hex_pat(2, 0), 10, 1);
    show(2, hex_pat(1, 0), 10, 1);
    show(3, 8'hFF, 10, 2);
    repeat (6) step();
    chk("basic_frame_count", fv_count - n, 1);

    // lone g segment with dp on digit 2, dp on digit 0
    show(2, 8'b0111_1110, 10, 0);
    show(0, hex_pat(5, 1), 10, 0);
    show(1, hex_pat(10, 0), 9, 0);
    show(3, hex_pat(15, 0), 11, 1);
    repeat (6) step();

    // short dwell ignored, then glitch restarts settle
    show(0, hex_pat(6, 0), 9, 1);
    show(1, hex_pat(11, 1), 9, 1);
    show(2, hex_pat(13, 0), 9, 1);
    n = fv_count;
    show(3, hex_pat(7, 0), 3, 3);
    repeat (20) step();
    chk("short_dwell_no_frame", fv_count - n, 0);
    step();
    bus.an   = 4'b0111;
    bus.sseg = hex_pat(9, 0);
    repeat (2) step();
    bus.sseg = hex_pat(12, 1);
    g = cyc;
    model_capture(3, hex_pat(12, 1));
    repeat (9) step();
    bus.an   = 4'hF;
    bus.sseg = 8'hFF;
    repeat (4) step();
    chk("glitch_latency", fv_cyc - g, 8);

    // timeout
    show(0, hex_pat(1, 0), 9, 1);
    show(1, hex_pat(2, 0), 9, 1);
    show(2, hex_pat(4, 0), 9, 1);
    show(3, hex_pat(8, 0), 10, 1);
    t = drv_cyc;
    wait_cyc(t + 106);
    chk("stale_before_timeout", {31'h0, bus.stale}, 32'h0);
    wait_cyc(t + 107);
    chk("stale_at_timeout", {31'h0, bus.stale}, 32'h1);
    wait_cyc(t + 150);
    chk("stale_saturated", {31'h0, bus.stale}, 32'h1);
    step();
    bus.an   = 4'b1110;
    bus.sseg = hex_pat(14, 0);
    f = cyc;
    model_capture(0, hex_pat(14, 0));
    wait_cyc(f + 6);
    chk("stale_until_capture", {31'h0, bus.stale}, 32'h1);
    wait_cyc(f + 7);
    chk("stale_cleared", {31'h0, bus.stale}, 32'h0);
    show(1, hex_pat(0, 0), 9, 0);
    show(2, hex_pat(3, 1), 9, 0);
    show(3, hex_pat(9, 0), 9, 1);
    repeat (6) step();

    // multiple anodes low
    step();
    bus.an   = 4'b1010;
    bus.sseg = hex_pat(1, 0);
    repeat (5) step();
    bus.an   = 4'hF;
    bus.sseg = 8'hFF;
    repeat (4) step();
    chk("anode_err_set", {31'h0, bus.anode_err}, 32'h1);
    show(0, hex_pat(2, 0), 9, 1);
    @(negedge clk);
    chk("anode_err_sticky", {31'h0, bus.anode_err}, 32'h1);
    step();
    reset  = 1'b0;
    m_seen = 4'h0;
    @(negedge clk);
    chk("anode_err_cleared", {31'h0, bus.anode_err}, 32'h0);
    step();
    reset = 1'b1;

    // reset with a partial frame pending
    show(0, hex_pat(7, 0), 9, 1);
    show(1, hex_pat(8, 0), 9, 1);
    show(2, hex_pat(9, 0), 9, 1);
    n = fv_count;
    step();
    reset  = 1'b0;
    m_seen = 4'h0;
    repeat (2) step();
    @(negedge clk);
    check_all_zero("midreset");
    step();
    reset = 1'b1;
    show(3, hex_pat(1, 0), 9, 1);
    show(2, hex_pat(2, 0), 9, 1);
    show(1, hex_pat(3, 1), 9, 1);
    show(0, hex_pat(4, 0), 9, 1);
    repeat (6) step();
    chk("midreset_one_frame", fv_count - n, 1);

    // randomized scan
    prev = -1;
    repeat (160) begin
      do idx = int'($urandom_range(0, 3)); while (idx == prev);
      r = int'($urandom_range(0, 9));
      if (r < 7)       pat = hex_pat(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      else if (r == 7) pat = {1'($urandom_range(0, 1)), 7'h7F};
      else             pat = 8'($urandom);
      dwell = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(8, 12));
      gap   = int'($urandom_range(0, 2));
      show(idx, pat, dwell, gap);
      prev = idx;
    end
    step();
    bus.an   = 4'hF;
    bus.sseg = 8'hFF;
    repeat (12) step();
    chk("pending_frames", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
